mem_stage: RTL and testbench

- MEM-stage consumer of the EX/MEM pipeline register outputs; drives the MEM/WB register inputs.
- ALU, HI/LO and move results pass straight through.
- Loads and stores run a single-outstanding req/ack transaction on the data bus.
- The stage stalls the upstream pipeline via stallreq until the access completes, faults or times out.
- Big-endian byte lanes: address offset 0 maps to bits 31:24.

---
 rtl/mem_stage_pkg.sv | 45 ++++
 rtl/mem_stage_lane_fmt.sv | 83 ++++++++
 rtl/mem_stage.sv | 157 +++++++++++++++
 tb/tb_mem_stage.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: operation codes, bus widths,
// FSM state encoding and byte/halfword lane helpers (big-endian lanes).
package mem_stage_pkg;

  localparam int          REG_BUS      = 32;
  localparam int          REG_ADDR_BUS = 5;
  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
  localparam logic        WRITE_ENABLE  = 1'b1;
  localparam logic        WRITE_DISABLE = 1'b0;
  localparam logic [4:0]  NOP_REG_ADDR = 5'b00000;

  // Operation codes seen on mem_aluop
  localparam logic [7:0] EXE_NOP_OP = 8'b0000_0000;
  localparam logic [7:0] EXE_ADD_OP = 8'b0010_0000;
  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mem_state_t;

  // Byte at offset lo; offset 0 is bits 31:24
  function automatic logic [7:0] get_byte(input logic [31:0] word, input logic [1:0] lo);
    case (lo)
      2'd0:    get_byte = word[31:24];
      2'd1:    get_byte = word[23:16];
      2'd2:    get_byte = word[15:8];
      default: get_byte = word[7:0];
    endcase
  endfunction

  // Halfword selected by address bit 1; bit 1 = 0 is bits 31:16
  function automatic logic [15:0] get_half(input logic [31:0] word, input logic hi_sel);
    get_half = hi_sel ? word[15:0] : word[31:16];
  endfunction

endpackage

// File: rtl/mem_stage_lane_fmt.sv
// Combinational lane logic: decodes the memory op, flags misalignment,
// builds byte enables and replicated store data, and extracts/extends
// load data from a captured bus word.
module mem_lane_fmt
  import mem_stage_pkg::*;
(
  input  logic [7:0]  aluop,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic        is_load,
  output logic        is_store,
  output logic        misaligned,
  output logic [3:0]  sel,
  output logic [31:0] store_lanes,
  output logic [31:0] load_data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign lane_b = get_byte(load_word, addr_lo);
  assign lane_h = get_half(load_word, addr_lo[1]);

  // Decode op into lane enables, store replication and load extension
  always_comb begin
    is_load     = 1'b0;
    is_store    = 1'b0;
    misaligned  = 1'b0;
    sel         = 4'b0000;
    store_lanes = ZERO_WORD;
    load_data   = ZERO_WORD;
    case (aluop)
      EXE_LB_OP: begin
        is_load   = 1'b1;
        sel       = 4'b1000 >> addr_lo;
        load_data = {{24{lane_b[7]}}, lane_b};
      end
      EXE_LBU_OP: begin
        is_load   = 1'b1;
        sel       = 4'b1000 >> addr_lo;
        load_data = {24'h000000, lane_b};
      end
      EXE_LH_OP: begin
        is_load    = 1'b1;
        misaligned = addr_lo[0];
        sel        = addr_lo[1] ? 4'b0011 : 4'b1100;
        load_data  = {{16{lane_h[15]}}, lane_h};
      end
      EXE_LHU_OP: begin
        is_load    = 1'b1;
        misaligned = addr_lo[0];
        sel        = addr_lo[1] ? 4'b0011 : 4'b1100;
        load_data  = {16'h0000, lane_h};
      end
      EXE_LW_OP: begin
        is_load    = 1'b1;
        misaligned = (addr_lo != 2'b00);
        sel        = 4'b1111;
        load_data  = load_word;
      end
      EXE_SB_OP: begin
        is_store    = 1'b1;
        sel         = 4'b1000 >> addr_lo;
        store_lanes = {4{store_data[7:0]}};
      end
      EXE_SH_OP: begin
        is_store    = 1'b1;
        misaligned  = addr_lo[0];
        sel         = addr_lo[1] ? 4'b0011 : 4'b1100;
        store_lanes = {2{store_data[15:0]}};
      end
      EXE_SW_OP: begin
        is_store    = 1'b1;
        misaligned  = (addr_lo != 2'b00);
        sel         = 4'b1111;
        store_lanes = store_data;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: passes ALU/HI/LO results to MEM/WB and runs one
// outstanding load/store on the data bus, stalling upstream until the
// access completes or times out.
//
// Bus handshake: dbus_req is registered and, once raised, holds together
// with dbus_we/sel/addr/wdata unchanged until the cycle in which dbus_ack
// is sampled high (or the timeout expires); dbus_ack is a single-cycle
// completion strobe, dbus_rdata is valid only with it, and ack is ignored
// whenever no request is outstanding.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  mem_wd,
  input  logic        mem_wreg,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] mem_hi,
  input  logic [31:0] mem_lo,
  input  logic        mem_whilo,
  input  logic [7:0]  mem_aluop,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_reg2,
  output logic [4:0]  wb_wd,
  output logic        wb_wreg,
  output logic [31:0] wb_wdata,
  output logic [31:0] wb_hi,
  output logic [31:0] wb_lo,
  output logic        wb_whilo,
  output logic        stallreq,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [3:0]  dbus_sel,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  input  logic [31:0] dbus_rdata,
  input  logic        dbus_ack,
  output logic        addr_err,
  output logic        bus_err
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  mem_state_t  state;
  logic [7:0]  cnt;
  logic        err_q;
  logic [31:0] rdata_q;

  logic        is_load;
  logic        is_store;
  logic        misaligned;
  logic [3:0]  fmt_sel;
  logic [31:0] fmt_wdata;
  logic [31:0] fmt_load;
  logic        start_access;

  mem_lane_fmt u_fmt (
    .aluop      (mem_aluop),
    .addr_lo    (mem_addr[1:0]),
    .store_data (mem_reg2),
    .load_word  (rdata_q),
    .is_load    (is_load),
    .is_store   (is_store),
    .misaligned (misaligned),
    .sel        (fmt_sel),
    .store_lanes(fmt_wdata),
    .load_data  (fmt_load)
  );

  assign start_access = (is_load || is_store) && !misaligned;

  // Bus FSM: issue request, wait for ack or timeout, one DONE cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      dbus_req   <= 1'b0;
      dbus_we    <= 1'b0;
      dbus_sel   <= 4'b0000;
      dbus_addr  <= ZERO_WORD;
      dbus_wdata <= ZERO_WORD;
      rdata_q    <= ZERO_WORD;
      cnt        <= 8'd0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_access) begin
            dbus_req   <= 1'b1;
            dbus_we    <= is_store;
            dbus_sel   <= fmt_sel;
            dbus_addr  <= {mem_addr[31:2], 2'b00};
            dbus_wdata <= fmt_wdata;
            cnt        <= 8'd0;
            err_q      <= 1'b0;
            state      <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (dbus_ack) begin
            dbus_req <= 1'b0;
            rdata_q  <= dbus_rdata;
            err_q    <= 1'b0;
            state    <= ST_DONE;
          end else if (cnt == CNT_LAST) begin
            dbus_req <= 1'b0;
            err_q    <= 1'b1;
            state    <= ST_DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_DONE: begin
          // The pipeline advances on this edge, so the op is not reissued
          err_q <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Writeback mux, stall request and error pulses
  always_comb begin
    wb_wd    = mem_wd;
    wb_wreg  = mem_wreg;
    wb_wdata = mem_wdata;
    wb_hi    = mem_hi;
    wb_lo    = mem_lo;
    wb_whilo = mem_whilo;
    stallreq = 1'b0;
    addr_err = 1'b0;
    bus_err  = 1'b0;
    case (state)
      ST_IDLE: begin
        if ((is_load || is_store) && misaligned) begin
          wb_wreg  = WRITE_DISABLE;
          addr_err = 1'b1;
        end else if (start_access) begin
          stallreq = 1'b1;
        end
      end
      ST_BUSY: stallreq = 1'b1;
      ST_DONE: begin
        if (err_q) begin
          bus_err = 1'b1;
          wb_wreg = WRITE_DISABLE;
        end else if (is_load) begin
          wb_wdata = fmt_load;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: pass-through, aligned loads/stores with
// varied ack latency, misalignment, bus timeout and reset mid-access.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic        mem_whilo;
  logic [7:0]  mem_aluop;
  logic [31:0] mem_addr;
  logic [31:0] mem_reg2;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic [31:0] wb_hi;
  logic [31:0] wb_lo;
  logic        wb_whilo;
  logic        stallreq;
  logic        dbus_req;
  logic        dbus_we;
  logic [3:0]  dbus_sel;
  logic [31:0] dbus_addr;
  logic [31:0] dbus_wdata;
  logic [31:0] dbus_rdata;
  logic        dbus_ack;
  logic        addr_err;
  logic        bus_err;

  int tests  = 0;
  int failed = 0;

  // Clock
  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_wd    (mem_wd),
    .mem_wreg  (mem_wreg),
    .mem_wdata (mem_wdata),
    .mem_hi    (mem_hi),
    .mem_lo    (mem_lo),
    .mem_whilo (mem_whilo),
    .mem_aluop (mem_aluop),
    .mem_addr  (mem_addr),
    .mem_reg2  (mem_reg2),
    .wb_wd     (wb_wd),
    .wb_wreg   (wb_wreg),
    .wb_wdata  (wb_wdata),
    .wb_hi     (wb_hi),
    .wb_lo     (wb_lo),
    .wb_whilo  (wb_whilo),
    .stallreq  (stallreq),
    .dbus_req  (dbus_req),
    .dbus_we   (dbus_we),
    .dbus_sel  (dbus_sel),
    .dbus_addr (dbus_addr),
    .dbus_wdata(dbus_wdata),
    .dbus_rdata(dbus_rdata),
    .dbus_ack  (dbus_ack),
    .addr_err  (addr_err),
    .bus_err   (bus_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                       input logic [4:0] wd, input logic wreg, input logic [31:0] wdata);
    mem_aluop = op;
    mem_addr  = addr;
    mem_reg2  = reg2;
    mem_wd    = wd;
    mem_wreg  = wreg;
    mem_wdata = wdata;
  endtask

  // Runs an access already presented on the inputs (called at a sample
  // point of cycle 0). ack_at is the cycle in which ack is driven (-1 =
  // never). Returns at the sample point of the first cycle with stallreq low.
  task automatic access(input int ack_at, input logic [31:0] rdata,
                        output int stalls, output int unstable, output int req_seen,
                        output logic s_we, output logic [3:0] s_sel,
                        output logic [31:0] s_addr, output logic [31:0] s_wdata);
    stalls   = 0;
    unstable = 0;
    req_seen = 0;
    s_we = 1'b0; s_sel = 4'h0; s_addr = 32'h0; s_wdata = 32'h0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (!stallreq) break;
      stalls++;
      if (dbus_req) req_seen++;
      if (cyc == 1) begin
        s_we = dbus_we; s_sel = dbus_sel; s_addr = dbus_addr; s_wdata = dbus_wdata;
      end else if (cyc > 1) begin
        if (dbus_we !== s_we || dbus_sel !== s_sel || dbus_addr !== s_addr ||
            dbus_wdata !== s_wdata || dbus_req !== 1'b1) unstable++;
      end
      dbus_ack   = (cyc == ack_at);
      dbus_rdata = rdata;
      step();
      dbus_ack = 1'b0;
      #1;
    end
  endtask

  int          stalls, unstable, req_seen, req_hits;
  logic        s_we;
  logic [3:0]  s_sel;
  logic [31:0] s_addr, s_wdata;

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Directed sequence
  initial begin
    rst = 1'b1;
    dbus_ack = 1'b0;
    dbus_rdata = 32'h0;
    mem_hi = 32'h0; mem_lo = 32'h0; mem_whilo = 1'b0;
    drive(EXE_NOP_OP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    step();
    step();
    #1;
    check("rst_req",   32'(dbus_req),   32'h0);
    check("rst_we",    32'(dbus_we),    32'h0);
    check("rst_sel",   32'(dbus_sel),   32'h0);
    check("rst_addr",  dbus_addr,       32'h0);
    check("rst_wdata", dbus_wdata,      32'h0);
    check("rst_state", 32'(dut.state),  32'(ST_IDLE));
    rst = 1'b0;

    // ALU result passes straight through
    step();
    drive(EXE_ADD_OP, 32'h0, 32'h0, 5'd3, 1'b1, 32'h0000_1234);
    #1;
    check("add_wdata", wb_wdata,        32'h0000_1234);
    check("add_wd",    32'(wb_wd),      32'd3);
    check("add_wreg",  32'(wb_wreg),    32'd1);
    check("add_stall", 32'(stallreq),   32'd0);
    req_hits = 0;
    for (int i = 0; i < 3; i++) begin
      step(); #1;
      if (dbus_req) req_hits++;
    end
    check("add_no_req", 32'(req_hits), 32'd0);

    // LB 0x101, ack on first BUSY cycle; HI/LO pass through in DONE
    step();
    drive(EXE_LB_OP, 32'h0000_0101, 32'h0, 5'd5, 1'b1, 32'h0000_DEAD);
    mem_hi = 32'hCAFE_0001; mem_lo = 32'hBEEF_0002; mem_whilo = 1'b1;
    #1;
    access(1, 32'h1180_2233, stalls, unstable, req_seen, s_we, s_sel, s_addr, s_wdata);
    check("lb_stalls", 32'(stalls),   32'd2);
    check("lb_sel",    32'(s_sel),    32'b0100);
    check("lb_addr",   s_addr,        32'h0000_0100);
    check("lb_we",     32'(s_we),     32'd0);
    check("lb_wdata",  wb_wdata,      32'hFFFF_FF80);
    check("lb_wreg",   32'(wb_wreg),  32'd1);
    check("lb_hi",     wb_hi,         32'hCAFE_0001);
    check("lb_lo",     wb_lo,         32'hBEEF_0002);
    check("lb_whilo",  32'(wb_whilo), 32'd1);
    check("lb_donereq", 32'(dbus_req), 32'd0);
    step();
    drive(EXE_NOP_OP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    mem_whilo = 1'b0;
    #1;
    check("lb_after_state", 32'(dut.state), 32'(ST_IDLE));

    // LHU 0x102, ack delayed 5 cycles
    step();
    drive(EXE_LHU_OP, 32'h0000_0102, 32'h0, 5'd6, 1'b1, 32'h0);
    #1;
    access(6, 32'hAAAA_8001, stalls, unstable, req_seen, s_we, s_sel, s_addr, s_wdata);
    check("lhu_stalls",   32'(stalls),   32'd7);
    check("lhu_unstable", 32'(unstable), 32'd0);
    check("lhu_sel",      32'(s_sel),    32'b0011);
    check("lhu_addr",     s_addr,        32'h0000_0100);
    check("lhu_wdata",    wb_wdata,      32'h0000_8001);

    // LH 0x100, sign extension of upper halfword
    step();
    drive(EXE_LH_OP, 32'h0000_0100, 32'h0, 5'd6, 1'b1, 32'h0);
    #1;
    access(2, 32'h8001_7777, stalls, unstable, req_seen, s_we, s_sel, s_addr, s_wdata);
    check("lh_stalls", 32'(stalls), 32'd3);
    check("lh_sel",    32'(s_sel),  32'b1100);
    check("lh_wdata",  wb_wdata,    32'hFFFF_8001);

    // SH 0x202
    step();
    drive(EXE_SH_OP, 32'h0000_0202, 32'h1234_5678, 5'd0, 1'b0, 32'h0);
    #1;
    access(1, 32'h0, stalls, unstable, req_seen, s_we, s_sel, s_addr, s_wdata);
    check("sh_we",    32'(s_we),    32'd1);
    check("sh_sel",   32'(s_sel),   32'b0011);
    check("sh_wdata", s_wdata,      32'h5678_5678);
    check("sh_addr",  s_addr,       32'h0000_0200);
    check("sh_wreg",  32'(wb_wreg), 32'd0);

    // SB 0x203
    step();
    drive(EXE_SB_OP, 32'h0000_0203, 32'h0000_00AB, 5'd0, 1'b0, 32'h0);
    #1;
    access(1, 32'h0, stalls, unstable, req_seen, s_we, s_sel, s_addr, s_wdata);
    check("sb_sel",   32'(s_sel), 32'b0001);
    check("sb_wdata", s_wdata,    32'hABAB_ABAB);

    // LW 0x104
    step();
    drive(EXE_LW_OP, 32'h0000_0104, 32'h0, 5'd8, 1'b1, 32'h0);
    #1;
    access(3, 32'hDEAD_BEEF, stalls, unstable, req_seen, s_we, s_sel, s_addr, s_wdata);
    check("lw_sel",   32'(s_sel),   32'b1111);
    check("lw_addr",  s_addr,       32'h0000_0104);
    check("lw_wdata", wb_wdata,     32'hDEAD_BEEF);
    check("lw_wreg",  32'(wb_wreg), 32'd1);

    // Misaligned LW 0x103
    step();
    drive(EXE_LW_OP, 32'h0000_0103, 32'h0, 5'd7, 1'b1, 32'h0000_0099);
    #1;
    check("mis_addr_err", 32'(addr_err), 32'd1);
    check("mis_wreg",     32'(wb_wreg),  32'd0);
    check("mis_stall",    32'(stallreq), 32'd0);
    check("mis_wd",       32'(wb_wd),    32'd7);
    step(); #1;
    check("mis_no_req",   32'(dbus_req), 32'd0);
    // Misaligned LH 0x101
    drive(EXE_LH_OP, 32'h0000_0101, 32'h0, 5'd7, 1'b1, 32'h0);
    #1;
    check("mis_lh_err",   32'(addr_err), 32'd1);
    step(); #1;
    check("mis_lh_noreq", 32'(dbus_req), 32'd0);

    // LW 0x400 with no ack: bus timeout
    drive(EXE_LW_OP, 32'h0000_0400, 32'h0, 5'd9, 1'b1, 32'h0);
    #1;
    access(-1, 32'h0, stalls, unstable, req_seen, s_we, s_sel, s_addr, s_wdata);
    check("to_stalls",   32'(stalls),   32'd17);
    check("to_req_cyc",  32'(req_seen), 32'd16);
    check("to_bus_err",  32'(bus_err),  32'd1);
    check("to_wreg",     32'(wb_wreg),  32'd0);
    check("to_req_drop", 32'(dbus_req), 32'd0);
    step();
    drive(EXE_NOP_OP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    #1;
    check("to_err_pulse", 32'(bus_err), 32'd0);

    // Reset while BUSY, then a stray ack
    step();
    drive(EXE_LW_OP, 32'h0000_0300, 32'h0, 5'd4, 1'b1, 32'h0);
    #1;
    step(); #1;
    check("rb_busy_req", 32'(dbus_req), 32'd1);
    rst = 1'b1;
    drive(EXE_NOP_OP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    step();
    rst = 1'b0;
    #1;
    check("rb_req",   32'(dbus_req),  32'd0);
    check("rb_state", 32'(dut.state), 32'(ST_IDLE));
    drive(EXE_ADD_OP, 32'h0, 32'h0, 5'd9, 1'b1, 32'h0000_0055);
    dbus_ack = 1'b1;
    dbus_rdata = 32'hFFFF_FFFF;
    step();
    dbus_ack = 1'b0;
    #1;
    check("rb_ack_state", 32'(dut.state), 32'(ST_IDLE));
    check("rb_ack_req",   32'(dbus_req),  32'd0);
    check("rb_ack_wdata", wb_wdata,       32'h0000_0055);
    check("rb_ack_stall", 32'(stallreq),  32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
